// File: rtl/fwd_pkg.sv
// fwd_pkg: shared types and constants for the forwarding / hazard unit.
//   FWD_*      : ALU forward-select encodings (2'b11 is never driven)
//   FWD_REG_AW : register-address width used by the shadow slot struct
//   slot_t     : destination info for one in-flight instruction
//   slot_matches(): true when a slot supplies register r via forwarding
package fwd_pkg;

   localparam logic [1:0] FWD_REGFILE = 2'b00;
   localparam logic [1:0] FWD_EXMEM   = 2'b10;
   localparam logic [1:0] FWD_MEMWB   = 2'b01;

   localparam int unsigned FWD_REG_AW = 5;

   typedef struct packed {
      logic                  valid;
      logic                  regwrite;
      logic                  memread;
      logic [FWD_REG_AW-1:0] dst;
   } slot_t;

   // Register 0 is hard-wired, so a write to it is never a forwarding source.
   function automatic logic slot_matches(input slot_t s, input logic [FWD_REG_AW-1:0] r);
      return s.valid & s.regwrite & (s.dst != '0) & (s.dst == r);
   endfunction

endpackage

// File: rtl/fwd_select.sv
// fwd_select: priority compare of one ID source register against the EX and
// MEM shadow slots, producing the next ALU forward-select code.
// Ports:
//   src_i      : source register number of the ID instruction
//   uses_i     : the ID instruction actually reads src_i
//   kill_i     : a bubble is being inserted; force register-file select
//   ex_slot_i  : destination info of the instruction now in EX
//   mem_slot_i : destination info of the instruction now in MEM
//   sel_o      : next forward select (FWD_REGFILE / FWD_EXMEM / FWD_MEMWB)
module fwd_select
   import fwd_pkg::*;
(
   input  logic [FWD_REG_AW-1:0] src_i,
   input  logic                  uses_i,
   input  logic                  kill_i,
   input  slot_t                 ex_slot_i,
   input  slot_t                 mem_slot_i,
   output logic [1:0]            sel_o
);

   always_comb begin
      sel_o = FWD_REGFILE;
      if (uses_i && !kill_i) begin
         // EX holds the youngest producer, so it wins over MEM.
         if (slot_matches(ex_slot_i, src_i)) begin
            sel_o = FWD_EXMEM;
         end else if (slot_matches(mem_slot_i, src_i)) begin
            sel_o = FWD_MEMWB;
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: forwarding-select and load-use stall control for a 5-stage
// pipeline. Shadow slots mirror the destination info of the instructions in
// EX and MEM; forward selects are computed in ID and registered so they are
// valid during that instruction's EX cycle.
// Ports:
//   clk_i, rst_ni      : clock, synchronous active-low reset
//   freeze_i           : global hold; no slot or output register changes
//   flush_i            : kill the ID instruction; it enters EX as a bubble
//   id_*_i             : decoded fields of the instruction in ID
//   forward_a_o/b_o    : registered ALU forward selects for the EX instruction
//   stall_o            : hold PC and IF/ID (combinational)
//   bubble_o           : ID/EX loads a NOP on this edge (combinational)
//   stall_count_o      : saturating load-use stall count (FWD_STATS_EN only)
// Optional feature: define FWD_STATS_EN to add the stall counter and its port.
module fwd_hazard_unit
   import fwd_pkg::*;
#(
   parameter int unsigned REG_AW = FWD_REG_AW
`ifdef FWD_STATS_EN
  ,parameter int unsigned CNT_W  = 16
`endif
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              freeze_i,
   input  logic              flush_i,
   input  logic              id_valid_i,
   input  logic [REG_AW-1:0] id_rs_i,
   input  logic [REG_AW-1:0] id_rt_i,
   input  logic [REG_AW-1:0] id_rd_i,
   input  logic              id_uses_rs_i,
   input  logic              id_uses_rt_i,
   input  logic              id_regwrite_i,
   input  logic              id_memread_i,
   input  logic              id_regdst_i,
   output logic [1:0]        forward_a_o,
   output logic [1:0]        forward_b_o,
   output logic              stall_o,
   output logic              bubble_o
`ifdef FWD_STATS_EN
  ,output logic [CNT_W-1:0]  stall_count_o
`endif
);

   slot_t             ex_q, ex_d;
   slot_t             mem_q, mem_d;
   slot_t             id_slot;
   logic [1:0]        fwd_a_q, fwd_a_d;
   logic [1:0]        fwd_b_q, fwd_b_d;
   logic [REG_AW-1:0] id_dst;
   logic              load_use;

   assign id_dst = id_regdst_i ? id_rd_i : id_rt_i;

   always_comb begin
      id_slot          = '0;
      id_slot.valid    = id_valid_i;
      id_slot.regwrite = id_regwrite_i;
      id_slot.memread  = id_memread_i;
      id_slot.dst      = id_dst;
   end

   // A load in EX cannot forward yet; the dependent ID instruction waits one cycle.
   // A flushed instruction needs no hold, so flush suppresses the hazard.
   always_comb begin
      load_use = id_valid_i & ~flush_i & ex_q.valid & ex_q.memread & (ex_q.dst != '0) &
                 ((id_uses_rs_i & (ex_q.dst == id_rs_i)) |
                  (id_uses_rt_i & (ex_q.dst == id_rt_i)));
   end

   // Under freeze every stage is already held, so no local stall/bubble is needed.
   assign stall_o  = load_use & ~freeze_i;
   assign bubble_o = (load_use | flush_i) & ~freeze_i;

   fwd_select u_sel_a (
      .src_i      (id_rs_i),
      .uses_i     (id_uses_rs_i),
      .kill_i     (bubble_o),
      .ex_slot_i  (ex_q),
      .mem_slot_i (mem_q),
      .sel_o      (fwd_a_d)
   );

   // Computed even for immediate-operand instructions: store data uses this path.
   fwd_select u_sel_b (
      .src_i      (id_rt_i),
      .uses_i     (id_uses_rt_i),
      .kill_i     (bubble_o),
      .ex_slot_i  (ex_q),
      .mem_slot_i (mem_q),
      .sel_o      (fwd_b_d)
   );

   always_comb begin
      mem_d = ex_q;
      ex_d  = bubble_o ? slot_t'('0) : id_slot;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ex_q    <= '0;
         mem_q   <= '0;
         fwd_a_q <= FWD_REGFILE;
         fwd_b_q <= FWD_REGFILE;
      end else if (!freeze_i) begin
         ex_q    <= ex_d;
         mem_q   <= mem_d;
         fwd_a_q <= fwd_a_d;
         fwd_b_q <= fwd_b_d;
      end
   end

   assign forward_a_o = fwd_a_q;
   assign forward_b_o = fwd_b_q;

`ifdef FWD_STATS_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (stall_o && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign stall_count_o = cnt_q;
`endif

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Control-side partner of the execute-stage ALU: produces the ForwardA/ForwardB select codes the ALU consumes, and the load-use stall/bubble control for the 5-stage pipeline.
- Tracks destination-register info for instructions in EX and MEM in internal shadow slots, advanced in lockstep with the pipeline registers.
- Forward selects are computed in ID and registered, so they are valid during the instruction's EX cycle.

Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 16, stall-counter width (optional feature only).

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset, synchronous, active-low
- freeze  in  1  global pipeline hold (memory wait); no slot or output changes
- flush  in  1  kill instruction in ID (taken branch); it enters EX as a bubble
- id_valid  in  1  ID holds a real instruction
- id_rs  in  REG_AW  source register A of ID instruction
- id_rt  in  REG_AW  source register B of ID instruction
- id_rd  in  REG_AW  rd field of ID instruction
- id_uses_rs  in  1  instruction reads rs
- id_uses_rt  in  1  instruction reads rt (ALU operand or store data)
- id_regwrite  in  1  instruction writes the register file
- id_memread  in  1  instruction is a load
- id_regdst  in  1  destination is rd (1) or rt (0)
- forward_a  out  2  ALU ForwardA for instruction in EX
- forward_b  out  2  ALU ForwardB for instruction in EX
- stall  out  1  hold PC and IF/ID; combinational
- bubble  out  1  ID/EX loads a NOP this edge; combinational
- stall_count  out  CNT_W  load-use stalls since reset (FWD_STATS_EN only)

Behaviour:
- Encoding, fixed by the ALU:
  - 2'b00 register-file value
  - 2'b10 EX/MEM result
  - 2'b01 MEM/WB result
  - 2'b11 never driven (ALU treats it as invalid)
- Slots: ex_slot and mem_slot, each holding {valid, regwrite, memread, dst}.
  - dst is loaded as id_regdst ? id_rd : id_rt.
- A slot "matches" register r when: valid & regwrite & dst != 0 & dst == r.
- Load-use hazard, combinational:
  - Condition: id_valid & ~flush & ex_slot.valid & ex_slot.memread & ex_slot.dst != 0 & ((id_uses_rs & dst == id_rs) | (id_uses_rt & dst == id_rt)).
  - When set and ~freeze: stall = 1 and bubble = 1.
- bubble is also 1 when flush & ~freeze.
- Next forward_a:
  - If ~id_uses_rs or a bubble is being inserted: 00.
  - Else if ex_slot matches id_rs: 10. EX/MEM has priority, as the newest value.
  - Else if mem_slot matches id_rs: 01.
  - Else: 00.
- Next forward_b: same rules using id_rt and id_uses_rt. Computed even when the ALU will select the immediate, because the store-data path uses rtresult.
- Rising edge with ~freeze:
  - mem_slot <= ex_slot.
  - ex_slot <= bubble ? 0 : {id_valid, id_regwrite, id_memread, dst}.
  - forward_a/forward_b <= next values.
- Rising edge with freeze: all registers hold. stall and bubble are forced to 0 (the outer freeze already holds every stage).
- Latency: a hazard is detected in the same cycle (stall is combinational). Forward selects appear one cycle after ID, aligned with EX.
- A load-use hazard costs exactly 1 stall cycle. The next cycle the load sits in mem_slot, so 01 is selected.
- Reset (~rst_n at edge): slots cleared, forward_a/forward_b = 00, stall_count = 0. stall and bubble read 0 while the slots are empty. Reset mid-stall aborts the stall with no residue.
- Simultaneous flush and hazard: flush wins. Bubble is inserted and stall = 0, since the killed instruction needs no hold.
- Register 0 is never forwarded and never causes a stall.

Optional Feature:
- Macro FWD_STATS_EN.
- Defined: stall_count increments on every edge with stall & ~freeze & rst_n, and saturates at all-ones.
- Undefined: the port is absent and no counter logic exists.

Decomposition:
- Package fwd_pkg holds:
  - FWD_REGFILE = 2'b00, FWD_EXMEM = 2'b10, FWD_MEMWB = 2'b01
  - the slot struct typedef {valid, regwrite, memread, dst}
- One natural sub-module, fwd_select: the combinational priority compare of one source register against both slots. Instantiated twice, for A and B.

Test Plan:
- add $3 then add $4,$3,$5 back-to-back -> forward_a = 10 in the second instruction's EX cycle, forward_b = 00, stall never asserted.
- add $3; nop; sub $6,$7,$3 -> forward_b = 01, forward_a = 00.
- lw $2 then add $4,$2,$2 -> stall = bubble = 1 for one cycle, then forward_a = forward_b = 01. stall_count = 1 with FWD_STATS_EN.
- Writes to $0 followed by a reader of $0 -> selects stay 00, no stall.
- lw $2 with a dependent add in ID and flush = 1 together -> bubble = 1, stall = 0, ex_slot invalid next cycle.
- Hazard pending with freeze = 1 for 3 cycles -> slots, selects and count unchanged. Then freeze = 0 -> exactly one stall. Reset asserted mid-stall -> all outputs 00/0 after the edge.
